// File: rtl/piso_serializer_if.sv
// Word-in / bit-out bus of the PISO serializer.
//   master : upstream word producer (drives data_in/data_valid, observes the rest)
//   slave  : the serializer itself
// Signals: data_in, data_valid, data_ready, serial_out, serial_valid,
//          frame_start, busy, bit_index ($clog2(DATA_WIDTH+1) bits).
interface piso_serializer_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned BW = $clog2(DATA_WIDTH + 1);

  logic [DATA_WIDTH-1:0] data_in;
  logic                  data_valid;
  logic                  data_ready;
  logic                  serial_out;
  logic                  serial_valid;
  logic                  frame_start;
  logic                  busy;
  logic [BW-1:0]         bit_index;

  modport master (
    output data_in, data_valid,
    input  data_ready, serial_out, serial_valid, frame_start, busy, bit_index
  );

  modport slave (
    input  data_in, data_valid,
    output data_ready, serial_out, serial_valid, frame_start, busy, bit_index
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with a one-word holding register so that
// frames can be emitted back-to-back without an idle cycle.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous active-high reset
//   bus    : piso_serializer_if.slave (word handshake in, serial bit stream out)
// Parameters:
//   DATA_WIDTH : bits per word (>= 2)
//   LSB_FIRST  : 1 -> bit 0 leaves first, 0 -> bit DATA_WIDTH-1 leaves first
// Build option:
//   PISO_PARITY_EN : append one even-parity bit (XOR of the word) to each frame
module piso_serializer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter bit          LSB_FIRST  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  piso_serializer_if.slave bus
);
  localparam int unsigned   BW       = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] LAST_IDX = BW'(DATA_WIDTH - 1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

  state_t                state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] hold;
  logic                  hold_full;
  logic [BW-1:0]         bit_cnt;
  logic                  serial_out_q;
  logic                  serial_valid_q;
  logic                  frame_start_q;
  logic                  busy_q;
`ifdef PISO_PARITY_EN
  logic                  parity_q;
`endif

  logic                  accept;
  logic                  finishing;
  logic                  shifter_free;
  logic                  load_hold;
  logic                  load_direct;
  logic                  to_hold;
  logic                  do_load;
  logic [DATA_WIDTH-1:0] load_word;

  // Bit that leaves first from a (remaining) word.
  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
    return LSB_FIRST ? w[0] : w[DATA_WIDTH-1];
  endfunction

  // Drop the bit just emitted so the next one sits at the output end.
  function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] w);
    return LSB_FIRST ? (w >> 1) : (w << 1);
  endfunction

  assign accept = bus.data_valid && !hold_full;

  // Shifter frees up on this edge when the frame's final bit is on the wire.
`ifdef PISO_PARITY_EN
  assign finishing = (state == PARITY);
`else
  assign finishing = (state == SHIFT) && (bit_cnt == LAST_IDX);
`endif

  // Load routing: hold has priority; a fresh word bypasses hold only when
  // the shifter frees up and hold is empty, otherwise it parks in hold.
  assign shifter_free = (state == IDLE) || finishing;
  assign load_hold    = shifter_free && hold_full;
  assign load_direct  = shifter_free && !hold_full && accept;
  assign to_hold      = accept && !shifter_free;
  assign do_load      = load_hold || load_direct;
  assign load_word    = load_hold ? hold : bus.data_in;

  // Frame FSM, shifter and holding register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      shreg          <= '0;
      hold           <= '0;
      hold_full      <= 1'b0;
      bit_cnt        <= '0;
      serial_out_q   <= 1'b0;
      serial_valid_q <= 1'b0;
      frame_start_q  <= 1'b0;
      busy_q         <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_q       <= 1'b0;
`endif
    end else begin
      if (load_hold) begin
        hold_full <= 1'b0;
      end else if (to_hold) begin
        hold      <= bus.data_in;
        hold_full <= 1'b1;
      end

      if (do_load) begin
        state          <= SHIFT;
        shreg          <= advance(load_word);
        serial_out_q   <= first_bit(load_word);
        serial_valid_q <= 1'b1;
        frame_start_q  <= 1'b1;
        bit_cnt        <= '0;
        busy_q         <= 1'b1;
`ifdef PISO_PARITY_EN
        parity_q       <= ^load_word;
`endif
      end else begin
        case (state)
          SHIFT: begin
            if (bit_cnt == LAST_IDX) begin
`ifdef PISO_PARITY_EN
              state          <= PARITY;
              serial_out_q   <= parity_q;
              bit_cnt        <= BW'(DATA_WIDTH);
              frame_start_q  <= 1'b0;
              busy_q         <= 1'b1;
`else
              state          <= IDLE;
              serial_out_q   <= 1'b0;
              serial_valid_q <= 1'b0;
              frame_start_q  <= 1'b0;
              bit_cnt        <= '0;
              busy_q         <= 1'b0;
`endif
            end else begin
              shreg          <= advance(shreg);
              serial_out_q   <= first_bit(shreg);
              bit_cnt        <= bit_cnt + BW'(1);
              frame_start_q  <= 1'b0;
              busy_q         <= 1'b1;
            end
          end
          default: begin
            // IDLE with nothing to load, or a frame ending with nothing queued.
            state          <= IDLE;
            serial_out_q   <= 1'b0;
            serial_valid_q <= 1'b0;
            frame_start_q  <= 1'b0;
            bit_cnt        <= '0;
            busy_q         <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.data_ready   = ~hold_full;
  assign bus.serial_out   = serial_out_q;
  assign bus.serial_valid = serial_valid_q;
  assign bus.frame_start  = frame_start_q;
  assign bus.busy         = busy_q;
  assign bus.bit_index    = bit_cnt;
endmodule
